// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
// CHECKSUM_EN (optional) adds the CHK/ERR states in imem_loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_DATA = 3'd2,
    S_CHK  = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } state_t;

  localparam logic [7:0] NOP_DEFAULT = 8'h00;

endpackage

// File: rtl/imem_ram.sv
// Instruction RAM: synchronous write port, asynchronous read port.
// Contents are deliberately not reset.
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into instruction RAM and holds the CPU
// in reset until the image is complete. Optional checksum: `define CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int              ADDR_W = 8,
  parameter int              DATA_W = 8,
  parameter logic [DATA_W-1:0] NOP  = NOP_DEFAULT
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              load_start,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] Read_Address,
  output logic [DATA_W-1:0] instruction,
  output logic              cpu_rst,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W-1:0] wr_count
);

  state_t            state_q, state_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] len_q, len_d;
  // Write pointer and byte count always move together, so one counter serves both.
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              we;
  logic              xfer;
  logic              last;
  logic [DATA_W-1:0] rdata;

`ifdef CHECKSUM_EN
  logic              err_q, err_d;
  logic [DATA_W-1:0] xor_q, xor_d;
`endif

  assign load_busy = (state_q == S_HDR) || (state_q == S_DATA) ||
                     (state_q == S_CHK);
  assign in_ready  = load_busy;
  assign xfer      = in_valid & in_ready;
  // len == 0 means a full 2**ADDR_W image: the match then comes on the wrap.
  assign last      = ADDR_W'(cnt_q + 1'b1) == len_q;

  always_comb begin
    state_d   = state_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = 1'b0;
    len_d     = len_q;
    cnt_d     = cnt_q;
    we        = 1'b0;
`ifdef CHECKSUM_EN
    err_d     = err_q;
    xor_d     = xor_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (load_start) state_d = S_HDR;
      end
      S_HDR: begin
        if (xfer) begin
          len_d   = in_data[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = S_DATA;
`ifdef CHECKSUM_EN
          xor_d   = '0;
`endif
        end
      end
      S_DATA: begin
        if (xfer) begin
          we    = 1'b1;
          cnt_d = cnt_q + 1'b1;
`ifdef CHECKSUM_EN
          xor_d = xor_q ^ in_data;
          if (last) state_d = S_CHK;
`else
          if (last) begin
            state_d   = S_DONE;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHK: begin
        if (xfer) begin
          if (in_data == xor_q) begin
            state_d   = S_DONE;
            cpu_rst_d = 1'b0;
            done_d    = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_ERR: begin
        if (load_start) begin
          state_d   = S_HDR;
          cpu_rst_d = 1'b1;
          err_d     = 1'b0;
        end
      end
`endif
      S_DONE: begin
        if (load_start) begin
          state_d   = S_HDR;
          cpu_rst_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cpu_rst_q <= 1'b1;
      done_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
`ifdef CHECKSUM_EN
      err_q     <= 1'b0;
      xor_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cpu_rst_q <= cpu_rst_d;
      done_q    <= done_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
`ifdef CHECKSUM_EN
      err_q     <= err_d;
      xor_q     <= xor_d;
`endif
    end
  end

  imem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .CLK  (CLK),
    .we   (we),
    .waddr(cnt_q),
    .wdata(in_data),
    .raddr(Read_Address),
    .rdata(rdata)
  );

  assign instruction = load_busy ? NOP : rdata;
  assign cpu_rst     = cpu_rst_q;
  assign load_done   = done_q;
  assign wr_count    = cnt_q;
`ifdef CHECKSUM_EN
  assign load_err    = err_q;
`else
  assign load_err    = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: randomized images against an array model.
module tb_imem_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       load_start;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] Read_Address;
  logic [7:0] instruction;
  logic       cpu_rst;
  logic       load_busy;
  logic       load_done;
  logic       load_err;
  logic [7:0] wr_count;

  imem_loader dut (
    .CLK(CLK), .RST(RST), .load_start(load_start),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .Read_Address(Read_Address), .instruction(instruction),
    .cpu_rst(cpu_rst), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .wr_count(wr_count)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit         err;
    logic [7:0] cnt;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        ev;
  logic [7:0] mdl[256];
  bit         known[256];
  bit         err_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Present one byte, hold it until the loader takes it.
  task automatic send(input logic [7:0] b, input int gap);
    bit got = 1'b0;
    repeat (gap) tick();
    in_valid = 1'b1;
    in_data  = b;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge CLK);
      if (in_ready) begin
        @(posedge CLK);
        #1;
        got = 1'b1;
      end
    end
    if (!got) chk("ready_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("hdr_in_ready", in_ready, 1);
    chk("hdr_busy", load_busy, 1);
    chk("hdr_cpu_rst", cpu_rst, 1);
    chk("hdr_load_err", load_err, 0);
  endtask

  task automatic readback();
    for (int a = 0; a < 256; a++) begin
      if (known[a]) begin
        Read_Address = 8'(a);
        #1;
        chk($sformatf("mem[%0d]", a), instruction, mdl[a]);
      end
    end
  endtask

  // mode 0: random data, 1: ramp (byte i = i), 2: explicit bytes A1,B2,C3
  task automatic load_image(input int len, input int maxgap, input int mode,
                            input bit bad_sum, input bit mid_start);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    bit         fail_exp;
`ifdef CHECKSUM_EN
    fail_exp = bad_sum;
`else
    fail_exp = 1'b0;
`endif
    start_load();
    exp_q.push_back('{err: fail_exp, cnt: 8'(len)});
    send(8'(len), $urandom_range(0, maxgap));
    Read_Address = 8'($urandom);
    #1;
    chk("nop_while_loading", instruction, 8'h00);
    for (int i = 0; i < ((len == 0) ? 256 : len); i++) begin
      case (mode)
        1:       b = 8'(i);
        2:       b = 8'hA1 + 8'(8'h11 * i);
        default: b = 8'($urandom);
      endcase
      if (mid_start && i == len / 2) load_start = 1'b1;
      if (i == ((len == 0) ? 255 : len - 1)) begin
`ifndef CHECKSUM_EN
        chk("cpu_rst_before_last", cpu_rst, 1);
`endif
      end
      send(b, $urandom_range(0, maxgap));
      load_start = 1'b0;
      mdl[i % 256]   = b;
      known[i % 256] = 1'b1;
      x ^= b;
    end
`ifdef CHECKSUM_EN
    chk("cpu_rst_before_sum", cpu_rst, 1);
    send(bad_sum ? ~x : x, $urandom_range(0, maxgap));
`endif
    chk("cpu_rst_after_last", cpu_rst, fail_exp);
    chk("in_ready_after_last", in_ready, 0);
    chk("wr_count_final", wr_count, 8'(len));
    chk("load_err_final", load_err, fail_exp);
    tick();
    chk("done_one_cycle", load_done, 0);
    readback();
  endtask

  always @(negedge CLK) begin
    if (load_done || (load_err && !err_prev)) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_event", 1, 0);
      end else begin
        ev = exp_q.pop_front();
        chk("event_err", load_err, ev.err);
        chk("event_cnt", wr_count, ev.cnt);
        chk("event_cpu_rst", cpu_rst, ev.err);
      end
    end
    err_prev = load_err;
  end

  initial begin
    RST = 1'b1;
    load_start = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    Read_Address = 8'h00;
    for (int a = 0; a < 256; a++) known[a] = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
    chk("rst_cpu_rst", cpu_rst, 1);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_busy", load_busy, 0);
    chk("rst_done", load_done, 0);
    chk("rst_err", load_err, 0);
    chk("rst_wr_count", wr_count, 0);

    load_image(3, 0, 2, 1'b0, 1'b0);
    Read_Address = 8'h01;
    #1;
    chk("read_addr1", instruction, 8'hB2);

    load_image(3, 3, 2, 1'b0, 1'b0);
    load_image(0, 0, 1, 1'b0, 1'b0);

    // Abort mid-load: bytes already written must survive.
    start_load();
    send(8'h05, 0);
    send(8'h5A, 1);
    mdl[0] = 8'h5A;
    send(8'hC4, 2);
    mdl[1] = 8'hC4;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    chk("abort_cpu_rst", cpu_rst, 1);
    chk("abort_in_ready", in_ready, 0);
    chk("abort_busy", load_busy, 0);
    chk("abort_wr_count", wr_count, 0);
    readback();

    load_image(9, 2, 0, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) begin
      load_image($urandom_range(1, 40), 3, 0, 1'b0, k[0]);
    end

`ifdef CHECKSUM_EN
    load_image(3, 1, 0, 1'b0, 1'b0);
    load_image(3, 1, 0, 1'b1, 1'b0);
    repeat (2) tick();
    chk("err_held", load_err, 1);
    load_image(4, 1, 0, 1'b0, 1'b0);
`endif

    repeat (3) tick();
    chk("pending_events", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
